// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN image feeder.
//   - feeder_state_t : FSM state encoding
//   - label_t        : encoded class label plus error flag
//   - encode_label() : class vector -> 4-bit label
package cnn_pkg;

   localparam int         NUM_CLASSES    = 10;
   localparam logic [3:0] LABEL_NONE     = 4'hF;
   localparam logic [3:0] LABEL_TIMEOUT  = 4'hE;
   localparam int         IMG_PIXELS_DEF = 784;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFETCH,
      ST_STREAM,
      ST_WAIT_DONE,
      ST_REPORT
   } feeder_state_t;

   typedef struct packed {
      logic [3:0] label;
      logic       err;
   } label_t;

   // Lowest set index wins. Anything other than exactly one bit set is an error.
   function automatic label_t encode_label(input logic [NUM_CLASSES-1:0] cls);
      label_t      r;
      int unsigned n_set;
      r.label = LABEL_NONE;
      n_set   = 0;
      for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
         if (cls[i]) begin
            r.label = 4'(i);
            n_set++;
         end
      end
      r.err = (n_set != 1);
      return r;
   endfunction

endpackage

// File: rtl/feeder_img_buf.sv
// feeder_img_buf: simple dual-port image buffer, one write port for the host
// and one registered read port for the stream. The read register is the
// pixel driven to the CNN, so it holds whenever rd_en is low.
// Ports:
//   clk, rst          clock, async active-high reset (read register only)
//   wr_en/addr/data   host write port
//   rd_en/addr        streaming read request
//   rd_data           registered read data (1-cycle latency)
module feeder_img_buf #(
   parameter int DEPTH = 784,
   parameter int AW    = 10,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cnn_image_feeder.sv
// cnn_image_feeder: buffers one host image, starts the CNN, streams the
// pixels over cnn_din/cnn_din_ready, captures the class vector on cnn_done
// and reports an encoded label with a one-cycle result_valid.
// Optional build macro CNN_FEEDER_TIMEOUT_EN adds a watchdog in WAIT_DONE
// that reports LABEL_TIMEOUT after TIMEOUT_CYC cycles without cnn_done.
// Ports:
//   clk, rst                      clock, async active-high reset
//   wr_en/wr_addr/wr_data         host buffer write (IDLE only, in-range only)
//   go                            start one inference
//   busy                          accepted go .. result_valid
//   result_valid                  one-cycle result pulse
//   result_label/classes/err      result, held until overwritten
//   cnn_start                     one-cycle CNN start pulse
//   cnn_din, cnn_din_ready        pixel stream to the CNN
//   cnn_done, cnn_classes         CNN completion and class vector
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_IDLE      | host may write buffer, waiting for go
// ST_PREFETCH  | cnn_start high, pixel 0 being read onto cnn_din
// ST_STREAM    | pixel consumed on each ready cycle, next one fetched
// ST_WAIT_DONE | all pixels consumed, waiting for cnn_done
// ST_REPORT    | result_valid high, busy drops on exit
module cnn_image_feeder
   import cnn_pkg::*;
#(
   parameter int IMG_PIXELS  = IMG_PIXELS_DEF,
   parameter int AW          = 10,
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic signed [DW-1:0]   wr_data,
   input  logic                   go,
   output logic                   busy,
   output logic                   result_valid,
   output logic [3:0]             result_label,
   output logic [NUM_CLASSES-1:0] result_classes,
   output logic                   result_err,
   output logic                   cnn_start,
   output logic signed [DW-1:0]   cnn_din,
   input  logic                   cnn_din_ready,
   input  logic                   cnn_done,
   input  logic [NUM_CLASSES-1:0] cnn_classes
);

   if ((2 ** AW) < IMG_PIXELS || TIMEOUT_CYC < 1) begin : g_cfg_bad
      $error("cnn_image_feeder: AW too small for IMG_PIXELS or TIMEOUT_CYC < 1");
   end

   localparam logic [AW:0] PIX_END = (AW + 1)'(IMG_PIXELS);

   feeder_state_t state;
   // One bit wider than the address so it can reach IMG_PIXELS.
   logic [AW:0]   rd_ptr;
   logic          buf_wr;
   logic          buf_rd;
   logic [DW-1:0] buf_q;
   label_t        enc;

`ifdef CNN_FEEDER_TIMEOUT_EN
   localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYC - 1);
   logic [31:0] wdog;
`endif

   assign buf_wr = wr_en && (state == ST_IDLE) && ({1'b0, wr_addr} < PIX_END);
   // rd_ptr == PIX_END means the last pixel is already on cnn_din; its
   // consumption must not fetch anything, so cnn_din holds.
   assign buf_rd = (state == ST_PREFETCH) ||
                   ((state == ST_STREAM) && cnn_din_ready && !cnn_done &&
                    (rd_ptr != PIX_END));
   assign enc     = encode_label(cnn_classes);
   assign cnn_din = buf_q;

   feeder_img_buf #(
      .DEPTH (IMG_PIXELS),
      .AW    (AW),
      .DW    (DW)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_wr),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (buf_rd),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (buf_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         rd_ptr         <= '0;
         busy           <= 1'b0;
         result_valid   <= 1'b0;
         result_label   <= '0;
         result_classes <= '0;
         result_err     <= 1'b0;
         cnn_start      <= 1'b0;
`ifdef CNN_FEEDER_TIMEOUT_EN
         wdog           <= '0;
`endif
      end else begin
         cnn_start    <= 1'b0;
         result_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (go) begin
                  busy       <= 1'b1;
                  result_err <= 1'b0;
                  rd_ptr     <= '0;
                  cnn_start  <= 1'b1;
                  state      <= ST_PREFETCH;
               end
            end
            ST_PREFETCH: begin
               rd_ptr <= {{AW{1'b0}}, 1'b1};
               state  <= ST_STREAM;
            end
            ST_STREAM: begin
               if (cnn_done) begin
                  // CNN finished before the whole image was consumed.
                  result_classes <= cnn_classes;
                  result_label   <= enc.label;
                  result_err     <= 1'b1;
                  result_valid   <= 1'b1;
                  state          <= ST_REPORT;
               end else if (cnn_din_ready) begin
                  if (rd_ptr == PIX_END) begin
                     state <= ST_WAIT_DONE;
`ifdef CNN_FEEDER_TIMEOUT_EN
                     wdog  <= '0;
`endif
                  end else begin
                     rd_ptr <= rd_ptr + 1'b1;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (cnn_done) begin
                  result_classes <= cnn_classes;
                  result_label   <= enc.label;
                  result_err     <= enc.err;
                  result_valid   <= 1'b1;
                  state          <= ST_REPORT;
               end
`ifdef CNN_FEEDER_TIMEOUT_EN
               else if (wdog == WDOG_LAST) begin
                  result_classes <= '0;
                  result_label   <= LABEL_TIMEOUT;
                  result_err     <= 1'b1;
                  result_valid   <= 1'b1;
                  state          <= ST_REPORT;
               end else begin
                  wdog <= wdog + 1'b1;
               end
`endif
            end
            ST_REPORT: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_image_feeder.sv
// tb_cnn_image_feeder: self-checking bench for cnn_image_feeder. The bench
// plays both the host and the CNN; the expected image is an array, and the
// expected label comes from a bit-count based reference function.
module tb_cnn_image_feeder;

   localparam int NPIX = 784;
   localparam int AW   = 10;
   localparam int DW   = 32;
`ifdef CNN_FEEDER_TIMEOUT_EN
   localparam int TB_TIMEOUT = 50;
`else
   localparam int TB_TIMEOUT = 1000000;
`endif

   logic                 clk;
   logic                 rst;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic signed [DW-1:0] wr_data;
   logic                 go;
   logic                 busy;
   logic                 result_valid;
   logic [3:0]           result_label;
   logic [9:0]           result_classes;
   logic                 result_err;
   logic                 cnn_start;
   logic signed [DW-1:0] cnn_din;
   logic                 cnn_din_ready;
   logic                 cnn_done;
   logic [9:0]           cnn_classes;

   int n_checks = 0;
   int n_pass   = 0;
   int start_cnt = 0;
   int img[NPIX];

   cnn_image_feeder #(
      .IMG_PIXELS  (NPIX),
      .AW          (AW),
      .DW          (DW),
      .TIMEOUT_CYC (TB_TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .go             (go),
      .busy           (busy),
      .result_valid   (result_valid),
      .result_label   (result_label),
      .result_classes (result_classes),
      .result_err     (result_err),
      .cnn_start      (cnn_start),
      .cnn_din        (cnn_din),
      .cnn_din_ready  (cnn_din_ready),
      .cnn_done       (cnn_done),
      .cnn_classes    (cnn_classes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (cnn_start === 1'b1) start_cnt++;

   // Reference label rule: no bits -> F, else lowest set index; error unless one bit.
   function automatic void ref_label(input logic [9:0] v, output logic [3:0] l, output logic e);
      int n;
      n = $countones(v);
      l = 4'hF;
      e = 1'b1;
      if (n != 0) begin
         for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
               l = 4'(i);
               break;
            end
         end
         e = (n > 1);
      end
   endfunction

   function automatic int data_errs(input int got[$]);
      int e;
      e = 0;
      for (int i = 0; i < got.size() && i < NPIX; i++)
         if (got[i] != img[i]) e++;
      return e;
   endfunction

   task automatic load_image(input bit rnd);
      @(negedge clk);
      for (int i = 0; i < NPIX; i++) begin
         img[i]  = rnd ? int'($urandom) : i - 392;
         wr_en   = 1'b1;
         wr_addr = 10'(i);
         wr_data = img[i];
         @(negedge clk);
      end
      wr_addr = 10'(1000);
      wr_data = 32'h5A5A_A5A5;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // Acts as the CNN: consumes n words, recording what was on cnn_din at each
   // ready-high edge and counting changes of cnn_din across ready-low cycles.
   task automatic stream(input bit bp, input int n, output int got[$], output int unstable);
      logic [DW-1:0] prev;
      bit            prev_ready;
      got        = {};
      unstable   = 0;
      prev_ready = 1'b1;
      prev       = '0;
      for (int k = 0; k < n; ) begin
         @(negedge clk);
         go    = 1'b0;
         wr_en = 1'b0;
         if (!prev_ready && cnn_din !== prev) unstable++;
         prev          = cnn_din;
         prev_ready    = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         cnn_din_ready = prev_ready;
         if (prev_ready) begin
            got.push_back(int'(cnn_din));
            k++;
         end
      end
      @(negedge clk);
      cnn_din_ready = 1'b0;
   endtask

   task automatic finish_done(input logic [9:0] cls, output logic rv, output logic [3:0] lbl,
                              output logic err, output logic [9:0] rc);
      cnn_done    = 1'b1;
      cnn_classes = cls;
      @(negedge clk);
      rv  = result_valid;
      lbl = result_label;
      err = result_err;
      rc  = result_classes;
      cnn_done    = 1'b0;
      cnn_classes = '0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, result_valid, result_label, result_classes, result_err, cnn_start, cnn_din} !== '0)
         $display("FAIL reset_outputs: got busy=%b rv=%b lbl=%h cls=%b err=%b start=%b din=%h expected all 0",
                  busy, result_valid, result_label, result_classes, result_err, cnn_start, cnn_din);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int got[$];
      int unst, s0;
      logic rv, err;
      logic [3:0] lbl;
      logic [9:0] rc;
      load_image(1'b0);
      s0 = start_cnt;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n_checks++;
      if (cnn_start !== 1'b1 || busy !== 1'b1)
         $display("FAIL basic_go_latency: got start=%b busy=%b expected 1 1", cnn_start, busy);
      else n_pass++;
      stream(1'b0, NPIX, got, unst);
      n_checks++;
      if (data_errs(got) !== 0)
         $display("FAIL basic_stream_data: got %0d mismatching words expected 0 (first=%0d want %0d)",
                  data_errs(got), got[0], img[0]);
      else n_pass++;
      n_checks++;
      if (start_cnt - s0 !== 1)
         $display("FAIL basic_start_pulses: got %0d expected 1", start_cnt - s0);
      else n_pass++;
      n_checks++;
      if (cnn_din !== img[NPIX-1])
         $display("FAIL basic_din_hold: got %0d expected %0d", cnn_din, img[NPIX-1]);
      else n_pass++;
      finish_done(10'b0000001000, rv, lbl, err, rc);
      n_checks++;
      if ({rv, lbl, err, rc} !== {1'b1, 4'd3, 1'b0, 10'b0000001000})
         $display("FAIL basic_result: got rv=%b lbl=%0d err=%b cls=%b expected rv=1 lbl=3 err=0 cls=0000001000",
                  rv, lbl, err, rc);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_report_one_cycle: got rv=%b busy=%b expected 0 0", result_valid, busy);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int got[$];
      int unst;
      logic rv, err, e_err;
      logic [3:0] lbl, e_lbl;
      logic [9:0] rc, oh;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      stream(1'b1, NPIX, got, unst);
      n_checks++;
      if (data_errs(got) !== 0)
         $display("FAIL bp_stream_data: got %0d mismatching words expected 0", data_errs(got));
      else n_pass++;
      n_checks++;
      if (unst !== 0)
         $display("FAIL bp_din_stable: got %0d changes during ready-low expected 0", unst);
      else n_pass++;
      oh = 10'b1 << $urandom_range(0, 9);
      ref_label(oh, e_lbl, e_err);
      finish_done(oh, rv, lbl, err, rc);
      n_checks++;
      if ({rv, lbl, err} !== {1'b1, e_lbl, e_err})
         $display("FAIL bp_result: got rv=%b lbl=%0d err=%b expected rv=1 lbl=%0d err=%b",
                  rv, lbl, err, e_lbl, e_err);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_bad_vectors();
      int got[$];
      int unst;
      logic rv, err, e_err;
      logic [3:0] lbl, e_lbl;
      logic [9:0] rc;
      logic [9:0] vecs[3];
      vecs[0] = 10'b1000000100;
      vecs[1] = 10'b0;
      vecs[2] = 10'($urandom);
      for (int v = 0; v < 3; v++) begin
         @(negedge clk);
         go = 1'b1;
         @(negedge clk);
         go = 1'b0;
         stream(1'b1, NPIX, got, unst);
         ref_label(vecs[v], e_lbl, e_err);
         finish_done(vecs[v], rv, lbl, err, rc);
         n_checks++;
         if ({rv, lbl, err, rc} !== {1'b1, e_lbl, e_err, vecs[v]})
            $display("FAIL bad_vec_%0d: got rv=%b lbl=%h err=%b cls=%b expected rv=1 lbl=%h err=%b cls=%b",
                     v, rv, lbl, err, rc, e_lbl, e_err, vecs[v]);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_early_done();
      int got[$];
      int unst, s0;
      logic rv, err;
      logic [3:0] lbl;
      logic [9:0] rc;
      logic [DW-1:0] din_hold;
      load_image(1'b1);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      stream(1'b0, 100, got, unst);
      n_checks++;
      if (data_errs(got) !== 0 || got.size() !== 100)
         $display("FAIL early_stream_data: got %0d mismatches over %0d words expected 0 over 100",
                  data_errs(got), got.size());
      else n_pass++;
      finish_done(10'b0010000000, rv, lbl, err, rc);
      n_checks++;
      if ({rv, lbl, err, rc} !== {1'b1, 4'd7, 1'b1, 10'b0010000000})
         $display("FAIL early_result: got rv=%b lbl=%0d err=%b cls=%b expected rv=1 lbl=7 err=1 cls=0010000000",
                  rv, lbl, err, rc);
      else n_pass++;
      @(negedge clk);
      s0 = start_cnt;
      din_hold = cnn_din;
      cnn_din_ready = 1'b1;
      repeat (10) @(negedge clk);
      cnn_din_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || cnn_din !== din_hold || start_cnt !== s0)
         $display("FAIL early_idle: got busy=%b din=%0d starts=%0d expected busy=0 din=%0d starts=%0d",
                  busy, cnn_din, start_cnt, din_hold, s0);
      else n_pass++;
      n_checks++;
      if (result_label !== 4'd7 || result_err !== 1'b1)
         $display("FAIL early_result_hold: got lbl=%0d err=%b expected lbl=7 err=1", result_label, result_err);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      int got[$];
      int unst;
      logic rv, err, e_err;
      logic [3:0] lbl, e_lbl;
      logic [9:0] rc, oh;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      stream(1'b1, 50, got, unst);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, result_valid, result_label, result_classes, result_err, cnn_start, cnn_din} !== '0)
         $display("FAIL midstream_reset: got busy=%b rv=%b lbl=%h cls=%b err=%b start=%b din=%h expected all 0",
                  busy, result_valid, result_label, result_classes, result_err, cnn_start, cnn_din);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      stream(1'b0, NPIX, got, unst);
      n_checks++;
      if (data_errs(got) !== 0)
         $display("FAIL post_reset_stream: got %0d mismatching words expected 0", data_errs(got));
      else n_pass++;
      oh = 10'b1 << $urandom_range(0, 9);
      ref_label(oh, e_lbl, e_err);
      finish_done(oh, rv, lbl, err, rc);
      n_checks++;
      if ({rv, lbl, err} !== {1'b1, e_lbl, e_err})
         $display("FAIL post_reset_result: got rv=%b lbl=%0d err=%b expected rv=1 lbl=%0d err=%b",
                  rv, lbl, err, e_lbl, e_err);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_busy_ignored();
      int got[$];
      int unst, s0, x;
      logic rv, err;
      logic [3:0] lbl;
      logic [9:0] rc;
      s0 = start_cnt;
      x  = int'($urandom);
      img[0] = x;
      @(negedge clk);
      go      = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 10'd0;
      wr_data = x;
      @(negedge clk);
      // DUT is busy now: this write and this go must both be dropped.
      wr_en   = 1'b1;
      wr_addr = 10'd5;
      wr_data = ~img[5];
      go      = 1'b1;
      stream(1'b0, NPIX, got, unst);
      n_checks++;
      if (data_errs(got) !== 0)
         $display("FAIL busy_stream_data: got %0d mismatches (word0=%0d want %0d, word5=%0d want %0d) expected 0",
                  data_errs(got), got[0], img[0], got[5], img[5]);
      else n_pass++;
      finish_done(10'b0000000001, rv, lbl, err, rc);
      n_checks++;
      if ({rv, lbl, err} !== {1'b1, 4'd0, 1'b0})
         $display("FAIL busy_result: got rv=%b lbl=%0d err=%b expected rv=1 lbl=0 err=0", rv, lbl, err);
      else n_pass++;
      repeat (10) @(negedge clk);
      n_checks++;
      if (start_cnt - s0 !== 1 || busy !== 1'b0)
         $display("FAIL busy_go_not_queued: got starts=%0d busy=%b expected starts=1 busy=0",
                  start_cnt - s0, busy);
      else n_pass++;
   endtask

`ifdef CNN_FEEDER_TIMEOUT_EN
   task automatic test_timeout();
      int got[$];
      int unst, k;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      stream(1'b1, NPIX, got, unst);
      k = 0;
      while (result_valid !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k !== TB_TIMEOUT)
         $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TB_TIMEOUT);
      else n_pass++;
      n_checks++;
      if ({result_label, result_err, result_classes} !== {4'hE, 1'b1, 10'b0})
         $display("FAIL timeout_result: got lbl=%h err=%b cls=%b expected lbl=e err=1 cls=0",
                  result_label, result_err, result_classes);
      else n_pass++;
      @(negedge clk);
   endtask
`endif

   initial begin
      rst           = 1'b1;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;
      go            = 1'b0;
      cnn_din_ready = 1'b0;
      cnn_done      = 1'b0;
      cnn_classes   = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_bad_vectors();
      test_early_done();
      test_reset_midstream();
      test_busy_ignored();
`ifdef CNN_FEEDER_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
